// File: rtl/control_pila_pkg.sv
// Shared constants and FSM state encoding for the arbitrated stack controller.
package control_pila_pkg;

   localparam int DATA_DEF = 8;
   localparam int PROF_DEF = 9;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      ESCRIBE = 2'd1,
      LEE     = 2'd2,
      FALLO   = 2'd3
   } estado_t;

endpackage

// File: rtl/control_pila_if.sv
// Requester-side bus of the stack controller: two req/ack requesters plus status.
interface control_pila_if #(
   parameter int DATA = control_pila_pkg::DATA_DEF,
   parameter int PROF = control_pila_pkg::PROF_DEF
);
   logic            cpu_req;
   logic            cpu_push;
   logic [DATA-1:0] cpu_dato;
   logic            int_req;
   logic            int_push;
   logic [DATA-1:0] int_dato;
   logic            borra_error;
   logic            cpu_ack;
   logic            int_ack;
   logic [DATA-1:0] dato_salida;
   logic            llena;
   logic            vacia;
   logic [PROF:0]   nivel;
   logic            error;

   modport master (
      output cpu_req, cpu_push, cpu_dato, int_req, int_push, int_dato, borra_error,
      input  cpu_ack, int_ack, dato_salida, llena, vacia, nivel, error
   );

   modport slave (
      input  cpu_req, cpu_push, cpu_dato, int_req, int_push, int_dato, borra_error,
      output cpu_ack, int_ack, dato_salida, llena, vacia, nivel, error
   );
endinterface

// File: rtl/mem_pila.sv
// Stack storage: 2^PROF x DATA, synchronous write, registered read (1 cycle).
module mem_pila #(
   parameter int DATA = 8,
   parameter int PROF = 9
) (
   input  logic            clk,
   input  logic            we,
   input  logic [PROF-1:0] waddr,
   input  logic [DATA-1:0] wdat,
   input  logic            re,
   input  logic [PROF-1:0] raddr,
   output logic [DATA-1:0] rdat
);

   logic [DATA-1:0] mem [2**PROF];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdat;
      if (re) rdat <= mem[raddr];
   end

endmodule

// File: rtl/control_pila.sv
// Two-requester stack controller, interrupt has fixed priority; 2 cycles req->ack.
// Requests are held until ack; over/underflow parks the FSM in FALLO until borra_error.
module control_pila
   import control_pila_pkg::*;
#(
   parameter int DATA = DATA_DEF,
   parameter int PROF = PROF_DEF
) (
   input logic           clk,
   input logic           reset,
   control_pila_if.slave bus
);

   localparam logic [PROF:0]   LLENO = {1'b1, {PROF{1'b0}}};
   localparam logic [PROF:0]   UNO   = {{PROF{1'b0}}, 1'b1};
   localparam logic [PROF-1:0] UNO_A = {{(PROF-1){1'b0}}, 1'b1};

   estado_t         estado;
   logic [PROF:0]   nivel;
   logic            win_int;
   logic [DATA-1:0] dato_lat;
   logic            cpu_ack;
   logic            int_ack;
   logic            error;
   logic [DATA-1:0] dato_salida;

   logic            llena;
   logic            vacia;
   logic            sel_int;
   logic            sel_cpu;
   logic            grant;
   logic            g_push;
   logic [DATA-1:0] g_dato;
   logic            rd_en;
   logic [PROF-1:0] rd_addr;
   logic            wr_en;
   logic [PROF-1:0] wr_addr;
   logic [DATA-1:0] rd_dat;

   assign llena = (nivel == LLENO);
   assign vacia = (nivel == '0);

   // A requester still sees its own ack while req is high; mask it so the
   // finished operation is not granted a second time.
   always_comb begin
      sel_int = bus.int_req && !int_ack;
      sel_cpu = bus.cpu_req && !cpu_ack && !sel_int;
      grant   = (estado == REPOSO) && (sel_int || sel_cpu);
      g_push  = sel_int ? bus.int_push : bus.cpu_push;
      g_dato  = sel_int ? bus.int_dato : bus.cpu_dato;
      rd_en   = grant && !g_push && !vacia;
      rd_addr = nivel[PROF-1:0] - UNO_A;
      wr_en   = (estado == ESCRIBE);
      wr_addr = nivel[PROF-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado      <= REPOSO;
         nivel       <= '0;
         win_int     <= 1'b0;
         dato_lat    <= '0;
         cpu_ack     <= 1'b0;
         int_ack     <= 1'b0;
         error       <= 1'b0;
         dato_salida <= '0;
      end else begin
         cpu_ack <= 1'b0;
         int_ack <= 1'b0;
         case (estado)
            REPOSO: begin
               if (grant) begin
                  win_int  <= sel_int;
                  dato_lat <= g_dato;
                  if (g_push ? llena : vacia) begin
                     error  <= 1'b1;
                     estado <= FALLO;
                  end else if (g_push) begin
                     estado <= ESCRIBE;
                  end else begin
                     nivel  <= nivel - UNO;
                     estado <= LEE;
                  end
               end
            end
            ESCRIBE: begin
               nivel   <= nivel + UNO;
               int_ack <= win_int;
               cpu_ack <= !win_int;
               estado  <= REPOSO;
            end
            LEE: begin
               dato_salida <= rd_dat;
               int_ack     <= win_int;
               cpu_ack     <= !win_int;
               estado      <= REPOSO;
            end
            FALLO: begin
               if (bus.borra_error) begin
                  error  <= 1'b0;
                  estado <= REPOSO;
               end
            end
            default: estado <= REPOSO;
         endcase
      end
   end

   mem_pila #(.DATA(DATA), .PROF(PROF)) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdat  (dato_lat),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdat  (rd_dat)
   );

   assign bus.cpu_ack     = cpu_ack;
   assign bus.int_ack     = int_ack;
   assign bus.dato_salida = dato_salida;
   assign bus.llena       = llena;
   assign bus.vacia       = vacia;
   assign bus.nivel       = nivel;
   assign bus.error       = error;

endmodule

// File: doc/control_pila.md
CONTROL_PILA -- requirements
Module: control_pila

Interface
REQ-001 Parameter DATA, default 8, SHALL set the width of each stack word.
REQ-002 Parameter PROF, default 9, SHALL set log2 of the stack depth (2^PROF words, 512 by default).
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: reset SHALL be asynchronous and active-low.
REQ-005 Port cpu_req, input, 1: CPU requester operation request, held until cpu_ack.
REQ-006 Port cpu_push, input, 1: CPU operation select, 1 = push, 0 = pop; held with cpu_req.
REQ-007 Port cpu_dato, input, DATA: CPU push data.
REQ-008 Port int_req, input, 1: interrupt requester operation request, held until int_ack.
REQ-009 Port int_push, input, 1: interrupt operation select, 1 = push, 0 = pop.
REQ-010 Port int_dato, input, DATA: interrupt push data.
REQ-011 Port cpu_ack, output, 1: one-cycle completion pulse for the CPU operation.
REQ-012 Port int_ack, output, 1: one-cycle completion pulse for the interrupt operation.
REQ-013 Port dato_salida, output, DATA: popped word; valid in the ack cycle of a pop, held until the next pop completes.
REQ-014 Port llena, output, 1: stack full (count = 2^PROF).
REQ-015 Port vacia, output, 1: stack empty (count = 0).
REQ-016 Port nivel, output, PROF+1: current word count.
REQ-017 Port error, output, 1: sticky overflow/underflow flag.
REQ-018 Port borra_error, input, 1: clears error and returns the FSM to REPOSO.

Function
REQ-019 The FSM SHALL have the states REPOSO, ESCRIBE, LEE and FALLO.
REQ-020 In REPOSO, when both requests are present, the interrupt requester SHALL win (fixed priority); the losing request stays pending and receives no ack.
REQ-021 Push grant: the FSM SHALL go REPOSO->ESCRIBE. In ESCRIBE the block SHALL write the latched data at address nivel, increment nivel, pulse the winner's ack, and return to REPOSO.
REQ-022 Pop grant: the FSM SHALL decrement nivel, issue a read at the new nivel, and go to LEE. In LEE dato_salida SHALL load the read word, the winner's ack SHALL pulse, and the FSM SHALL return to REPOSO.
REQ-023 Latency SHALL be 2 cycles from request sampled to ack for both push and pop; peak throughput is one operation per 2 cycles.
REQ-024 The winner's operation and data SHALL be latched at grant; input changes after the grant SHALL have no effect on that operation.
REQ-025 A push granted while llena=1, or a pop granted while vacia=1, SHALL leave memory and nivel unchanged, set error, give no ack, and enter FALLO.
REQ-026 FALLO SHALL ignore all requests; borra_error=1 SHALL clear error and go to REPOSO on the next edge.
REQ-027 llena and vacia SHALL be combinational decodes of nivel; nivel SHALL never wrap.
REQ-028 The two acks SHALL never be asserted in the same cycle.

Reset
REQ-029 While reset=0: FSM in REPOSO, nivel=0, vacia=1, llena=0, error=0, both acks=0, dato_salida=0. Memory contents are not reset.
REQ-030 Reset asserted mid-operation SHALL abort the operation without an ack; a pending write SHALL NOT occur.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the default DATA/PROF constants.
REQ-032 Storage SHALL be one sub-module, mem_pila: synchronous write, registered read, 2^PROF x DATA.

Verification
REQ-033 After reset, CPU pushes 0x11, 0x22, then pops twice -> acks 2 cycles after each request, dato_salida 0x22 then 0x11, vacia=1 at the end.
REQ-034 cpu_req and int_req (push 0xA5) asserted in the same cycle -> int_ack first; cpu_ack 2 cycles later; nivel=2.
REQ-035 512 pushes -> llena=1, nivel=512; a 513th push -> error=1, no ack, nivel stays 512; borra_error -> REPOSO, error=0.
REQ-036 Pop on an empty stack -> error=1, no ack, nivel=0, dato_salida unchanged.
REQ-037 reset pulsed low in ESCRIBE during a push of 0x3C -> nivel=0, no ack, and a following pop reports underflow.
REQ-038 cpu_dato changed from 0x55 to 0xFF one cycle after grant -> popping back returns 0x55.
